// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared constants, FSM encoding and helpers for the LCD bus model.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] c_lcd_space  = 8'h20;

    localparam logic [6:0] c_line0_base = 7'h00;
    localparam logic [6:0] c_line1_base = 7'h40;
    localparam logic [6:0] c_line0_wrap = 7'h27;
    localparam logic [6:0] c_line1_wrap = 7'h67;

    localparam logic [7:0] c_msk_set_ddram = 8'h80;
    localparam logic [7:0] c_msk_no_effect = 8'h70;
    localparam logic [7:0] c_msk_disp_ctl  = 8'h08;
    localparam logic [7:0] c_msk_entry     = 8'h04;
    localparam logic [7:0] c_msk_home      = 8'h02;
    localparam logic [7:0] c_msk_clear     = 8'h01;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_exec  = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    localparam logic [2:0] c_op_nop    = 3'd0;
    localparam logic [2:0] c_op_set_ac = 3'd1;
    localparam logic [2:0] c_op_disp   = 3'd2;
    localparam logic [2:0] c_op_entry  = 3'd3;
    localparam logic [2:0] c_op_home   = 3'd4;
    localparam logic [2:0] c_op_clear  = 3'd5;

    // Highest set bit of the instruction selects the operation.
    function automatic logic [2:0] lcd_decode(input logic [7:0] d);
        logic [2:0] op;
        op = c_op_nop;
        if      (|(d & c_msk_set_ddram)) op = c_op_set_ac;
        else if (|(d & c_msk_no_effect)) op = c_op_nop;
        else if (|(d & c_msk_disp_ctl))  op = c_op_disp;
        else if (|(d & c_msk_entry))     op = c_op_entry;
        else if (|(d & c_msk_home))      op = c_op_home;
        else if (|(d & c_msk_clear))     op = c_op_clear;
        return op;
    endfunction

    function automatic logic ac_visible(input logic [6:0] ac);
        return (ac[5:4] == 2'b00);
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if      (ac == c_line0_wrap) nxt = c_line1_base;
            else if (ac == c_line1_wrap) nxt = c_line0_base;
            else                         nxt = ac + 7'd1;
        end else begin
            if      (ac == c_line1_base) nxt = c_line0_wrap;
            else if (ac == c_line0_base) nxt = c_line1_wrap;
            else                         nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram_buf.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ddram_buf
// Brief    : 32x8 character image, one sync write port, two async read ports.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ddram_buf (
    input  logic       clk,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_raddr_a,
    output logic [7:0] o_rdata_a,
    input  logic [4:0] i_raddr_b,
    output logic [7:0] o_rdata_b
);

    logic [7:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/lcd_rx_model.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rx_model
// Brief    : HD44780-style LCD bus receiver keeping a 2x16 character image.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_rx_model #(
    parameter int BUSY_CYC     = 4,
    parameter int BUSY_CYC_CLR = 40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    output logic [7:0] LCD_DOUT,
    input  logic [4:0] buf_addr,
    output logic [7:0] buf_char,
    output logic [6:0] ac,
    output logic       busy,
    output logic       disp_on,
    output logic       cmd_valid,
    output logic [8:0] cmd_code,
    output logic       err_busy
);
    import lcd_pkg::*;

    localparam int c_clr_tail = BUSY_CYC_CLR - 32;
    localparam int c_cnt_max  = (BUSY_CYC > c_clr_tail) ? BUSY_CYC : c_clr_tail;
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);

    logic               r_e_q;
    logic               r_rs;
    logic               r_rw;
    logic [7:0]         r_data;
    logic [1:0]         r_state;
    logic               r_busy;
    logic [4:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [6:0]         r_ac;
    logic               r_inc;
    logic               r_disp_on;
    logic [7:0]         r_dout;
    logic               r_cmd_valid;
    logic [8:0]         r_cmd_code;
    logic               r_err_busy;

    logic       w_fall;
    logic [2:0] w_op;
    logic       w_ac_vis;
    logic [4:0] w_ac_idx;
    logic [7:0] w_rd_char;
    logic       w_data_wr;
    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;
    logic [7:0] w_dout_next;

    assign w_fall    = r_e_q & ~LCD_E;
    assign w_op      = lcd_decode(r_data);
    assign w_ac_vis  = ac_visible(r_ac);
    assign w_ac_idx  = {r_ac[6], r_ac[3:0]};
    assign w_data_wr = w_fall & ~r_busy & ~r_rw & r_rs & w_ac_vis;

    assign w_we    = ~RST & ((r_state == c_st_clear) | w_data_wr);
    assign w_waddr = (r_state == c_st_clear) ? r_idx : w_ac_idx;
    assign w_wdata = (r_state == c_st_clear) ? c_lcd_space : r_data;

    // Read response follows the live bus; the busy flag comes from the register.
    always_comb begin
        w_dout_next = 8'h00;
        if (LCD_E && LCD_RW) begin
            if (LCD_RS) w_dout_next = w_ac_vis ? w_rd_char : c_lcd_space;
            else        w_dout_next = {r_busy, r_ac};
        end
    end

    lcd_ddram_buf u_buf (
        .clk       (CLK),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (buf_addr),
        .o_rdata_a (buf_char),
        .i_raddr_b (w_ac_idx),
        .o_rdata_b (w_rd_char)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_e_q       <= 1'b0;
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_data      <= 8'h00;
            r_state     <= c_st_clear;
            r_busy      <= 1'b1;
            r_idx       <= 5'd0;
            r_cnt       <= '0;
            r_ac        <= c_line0_base;
            r_inc       <= 1'b1;
            r_disp_on   <= 1'b0;
            r_dout      <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 9'h000;
            r_err_busy  <= 1'b0;
        end else begin
            r_e_q       <= LCD_E;
            r_cmd_valid <= 1'b0;
            r_err_busy  <= 1'b0;
            r_dout      <= w_dout_next;
            if (LCD_E) begin
                r_rs   <= LCD_RS;
                r_rw   <= LCD_RW;
                r_data <= LCD_DATA;
            end

            case (r_state)
                c_st_clear: begin
                    r_ac  <= c_line0_base;
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        if (c_clr_tail > 0) begin
                            r_state <= c_st_exec;
                            r_cnt   <= c_cnt_w'(c_clr_tail - 1);
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                c_st_exec: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            // A fall only acts while idle, so it never collides with the case above.
            if (w_fall) begin
                if (!r_rw && r_busy) begin
                    r_err_busy <= 1'b1;
                end else if (!r_rw) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_code  <= {r_rs, r_data};
                    r_state     <= c_st_exec;
                    r_busy      <= 1'b1;
                    r_cnt       <= c_cnt_w'(BUSY_CYC - 1);
                    if (r_rs) begin
                        r_ac <= ac_step(r_ac, r_inc);
                    end else begin
                        case (w_op)
                            c_op_set_ac: r_ac      <= r_data[6:0];
                            c_op_disp:   r_disp_on <= r_data[2];
                            c_op_entry:  r_inc     <= r_data[1];
                            c_op_home:   r_ac      <= c_line0_base;
                            c_op_clear: begin
                                r_state <= c_st_clear;
                                r_idx   <= 5'd0;
                                r_ac    <= c_line0_base;
                            end
                            default: ;
                        endcase
                    end
                end else if (r_rs && !r_busy) begin
                    r_ac <= ac_step(r_ac, r_inc);
                end
            end
        end
    end

    assign LCD_DOUT  = r_dout;
    assign ac        = r_ac;
    assign busy      = r_busy;
    assign disp_on   = r_disp_on;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign err_busy  = r_err_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_rx_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_rx_model
// Brief    : Directed bench for lcd_rx_model with an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_rx_model;

    logic       clk;
    logic       RST;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic [7:0] LCD_DOUT;
    logic [4:0] buf_addr;
    logic [7:0] buf_char;
    logic [6:0] ac;
    logic       busy;
    logic       disp_on;
    logic       cmd_valid;
    logic [8:0] cmd_code;
    logic       err_busy;

    typedef struct {
        bit         err;
        logic [8:0] code;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    lcd_rx_model #(.BUSY_CYC(4), .BUSY_CYC_CLR(40)) dut (
        .CLK       (clk),
        .RST       (RST),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .LCD_DOUT  (LCD_DOUT),
        .buf_addr  (buf_addr),
        .buf_char  (buf_char),
        .ac        (ac),
        .busy      (busy),
        .disp_on   (disp_on),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .err_busy  (err_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every cmd_valid / err_busy pulse must match the next queued event.
    always @(negedge clk) begin
        if (cmd_valid || err_busy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got valid=%0b err=%0b expected no event", cmd_valid, err_busy);
            end else begin
                ev_t ev;
                ev = sb.pop_front();
                chk("sb_kind", {31'd0, err_busy}, {31'd0, ev.err});
                if (!ev.err) chk("sb_code", {23'd0, cmd_code}, {23'd0, ev.code});
            end
        end
    end

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
        @(negedge clk);
        @(negedge clk);
        LCD_E = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input bit exp_err);
        sb.push_back('{err: exp_err, code: {rs, d}});
        xfer(rs, 1'b0, d);
    endtask

    task automatic rd(input logic rs, output logic [7:0] dout);
        LCD_RS = rs; LCD_RW = 1'b1; LCD_E = 1'b1;
        @(negedge clk);
        dout = LCD_DOUT;
        LCD_E = 1'b0;
        @(negedge clk);
        LCD_RW = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_buf(input int idx, input logic [7:0] exp, input string nm);
        buf_addr = idx[4:0];
        #1;
        chk($sformatf("%s[%0d]", nm, idx), {24'd0, buf_char}, {24'd0, exp});
        @(negedge clk);
    endtask

    task automatic chk_blank(input string nm);
        for (int i = 0; i < 32; i++) chk_buf(i, 8'h20, nm);
    endtask

    initial begin
        int         n;
        logic [7:0] d;
        RST = 1'b1; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DATA = 8'h00; buf_addr = 5'd0;

        // Reset state and initial sweep
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ac", {25'd0, ac}, 32'd0);
        chk("rst_dout", {24'd0, LCD_DOUT}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_err_busy", {31'd0, err_busy}, 32'd0);
        chk("rst_cmd_code", {23'd0, cmd_code}, 32'd0);
        chk("rst_disp_on", {31'd0, disp_on}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        count_busy(n);
        chk("rst_busy_len", n, 32'd40);
        chk("rst_ac_idle", {25'd0, ac}, 32'd0);
        chk_blank("rst_blank");

        // Init sequence then two characters
        wr(1'b0, 8'h38, 1'b0); wait_idle();
        wr(1'b0, 8'h0C, 1'b0); wait_idle();
        wr(1'b0, 8'h06, 1'b0); wait_idle();
        wr(1'b1, 8'h41, 1'b0); wait_idle();
        wr(1'b1, 8'h42, 1'b0); wait_idle();
        chk("init_disp_on", {31'd0, disp_on}, 32'd1);
        chk("init_ac", {25'd0, ac}, 32'h02);
        chk_buf(0, 8'h41, "init_buf");
        chk_buf(1, 8'h42, "init_buf");
        chk("init_events", sb.size(), 32'd0);

        // Line 2, line wraps and invisible addresses
        wr(1'b0, 8'hC0, 1'b0); wait_idle();
        wr(1'b1, 8'h31, 1'b0); wait_idle();
        chk_buf(16, 8'h31, "l2_buf");
        chk("l2_ac", {25'd0, ac}, 32'h41);
        wr(1'b0, 8'hE7, 1'b0); wait_idle();
        wr(1'b1, 8'h66, 1'b0); wait_idle();
        chk("wrap67_ac", {25'd0, ac}, 32'h00);
        chk_buf(0, 8'h41, "wrap67_buf");
        wr(1'b0, 8'hA7, 1'b0); wait_idle();
        wr(1'b1, 8'h55, 1'b0); wait_idle();
        chk("wrap27_ac", {25'd0, ac}, 32'h40);
        chk_buf(16, 8'h31, "wrap27_buf");
        chk_buf(17, 8'h20, "wrap27_buf");

        // Reads while idle
        rd(1'b1, d);
        chk("rd_data", {24'd0, d}, 32'h31);
        chk("rd_data_ac", {25'd0, ac}, 32'h41);
        chk("rd_dout_off", {24'd0, LCD_DOUT}, 32'h00);
        rd(1'b0, d);
        chk("rd_status", {24'd0, d}, 32'h41);

        // Busy handling
        wr(1'b0, 8'h0C, 1'b0);
        rd(1'b0, d);
        chk("rd_busy_status", {24'd0, d}, 32'hC1);
        wait_idle();
        wr(1'b0, 8'h0C, 1'b0);
        wr(1'b1, 8'h77, 1'b1);
        wait_idle();
        chk("busy_ac", {25'd0, ac}, 32'h41);
        chk_buf(17, 8'h20, "busy_buf");

        // Decrement mode, wrap below zero, then Clear Display
        wr(1'b0, 8'h04, 1'b0); wait_idle();
        wr(1'b0, 8'h80, 1'b0); wait_idle();
        wr(1'b1, 8'h58, 1'b0); wait_idle();
        chk_buf(0, 8'h58, "dec_buf");
        chk("dec_ac", {25'd0, ac}, 32'h67);
        wr(1'b0, 8'h01, 1'b0);
        count_busy(n);
        chk("clr_busy_len", n, 32'd40);
        chk("clr_ac", {25'd0, ac}, 32'h00);
        chk("clr_disp_on", {31'd0, disp_on}, 32'd1);
        chk_blank("clr_blank");

        // Reset in the middle of a sweep
        wr(1'b0, 8'h01, 1'b0);
        repeat (10) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        count_busy(n);
        chk("midrst_busy_len", n, 32'd40);
        chk("midrst_disp_on", {31'd0, disp_on}, 32'd0);
        chk("midrst_cmd_code", {23'd0, cmd_code}, 32'd0);
        chk_blank("midrst_blank");
        wr(1'b1, 8'h61, 1'b0); wait_idle();
        chk_buf(0, 8'h61, "midrst_buf");
        chk("midrst_ac", {25'd0, ac}, 32'h01);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
